// File: rtl/cpu_controller_if.sv
// cpu_controller_if: control bundle from the instruction decoder to the datapath.
interface cpu_controller_if;
  logic [2:0]  writenum;
  logic [2:0]  readnum;
  logic        write;
  logic [3:0]  vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  modport master (
    output writenum, readnum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, shift, ALUop, sximm8, sximm5
  );
  modport slave (
    input writenum, readnum, write, vsel, loada, loadb, loadc, loads,
          asel, bsel, shift, ALUop, sximm8, sximm5
  );
endinterface

// File: rtl/cpu_controller.sv
// cpu_controller: holds the instruction register and sequences the datapath controls per instruction.
module cpu_controller (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       in,
  input  logic              load,
  input  logic              s,
  output logic              w,
  output logic              illegal,
  cpu_controller_if.master  dp
);
  typedef enum logic [2:0] {WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE_REG} state_t;
  state_t state, state_nx;
  logic [15:0] ir;
  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic mov_imm, mov_reg, alu, cmp, two_src, one_src;
  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign mov_imm = opcode == 3'b110 && op == 2'b10;
  assign mov_reg = opcode == 3'b110 && op == 2'b00;
  assign alu     = opcode == 3'b101;
  assign cmp     = alu && op == 2'b01;
  // ADD/CMP/AND read Rn then Rm; MOV reg and MVN only read Rm with A forced to zero
  assign two_src = alu && op != 2'b11;
  assign one_src = mov_reg || (alu && op == 2'b11);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (state == WAIT && load) ir <= in;
    end
  end
  always_comb begin
    state_nx    = state;
    w           = 1'b0;
    illegal     = 1'b0;
    dp.writenum = 3'd0;
    dp.readnum  = 3'd0;
    dp.write    = 1'b0;
    dp.vsel     = 4'b1000;
    dp.loada    = 1'b0;
    dp.loadb    = 1'b0;
    dp.loadc    = 1'b0;
    dp.loads    = 1'b0;
    dp.asel     = 1'b0;
    dp.bsel     = 1'b0;
    dp.shift    = 2'b00;
    dp.ALUop    = 2'b00;
    dp.sximm8   = {{8{ir[7]}}, ir[7:0]};
    dp.sximm5   = {{11{ir[4]}}, ir[4:0]};
    case (state)
      WAIT: begin
        w        = 1'b1;
        state_nx = s ? DECODE : WAIT;
      end
      DECODE: begin
        illegal  = !(mov_imm || two_src || one_src);
        state_nx = mov_imm ? WRITE_IMM : two_src ? GET_A : one_src ? GET_B : WAIT;
      end
      WRITE_IMM: begin
        dp.vsel     = 4'b0010;
        dp.writenum = rn;
        dp.write    = 1'b1;
        state_nx    = WAIT;
      end
      GET_A: begin
        dp.readnum = rn;
        dp.loada   = 1'b1;
        state_nx   = GET_B;
      end
      GET_B: begin
        dp.readnum = rm;
        dp.loadb   = 1'b1;
        state_nx   = EXEC;
      end
      EXEC: begin
        dp.shift = sh;
        dp.ALUop = op;
        dp.asel  = one_src;
        dp.loads = cmp;
        dp.loadc = !cmp;
        state_nx = cmp ? WAIT : WRITE_REG;
      end
      WRITE_REG: begin
        dp.writenum = rd;
        dp.write    = 1'b1;
        state_nx    = WAIT;
      end
      default: state_nx = WAIT;
    endcase
  end
endmodule
